fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised hazard and forwarding unit for the 5-stage MIPS pipeline. Replaces the per-stage forwarding muxes with one
//  block that tracks every in-flight GRF write (dest, Tnew) along the EX..WB producer stages.
//  It raises stall on Tuse/Tnew conflicts and muxes forwarded operands for the ID-stage read ports.
//  It also re-forwards the same operands one cycle later, in EX, from registered copies.
// PARAMETERS
//  DW    32  GRF data width
//  AW    5   GRF address width; address 0 is never forwarded and never stalls
//  NRP   2   read ports per instruction (rs, rt)
//  NSTG  3   producer stages tracked after ID; index 0 = EX, NSTG-1 = WB
//  TW    2   width of Tnew/Tuse fields
// PORTS
//  clk          in   1         pipeline clock
//  reset        in   1         synchronous, active-high
//  id_wa        in   AW        dest reg of instruction in ID (0 = no write)
//  id_tnew      in   TW        cycles after entering EX until its result is forwardable
//  id_ra        in   NRP*AW    read addresses in ID, port p at [p*AW+:AW]
//  id_tuse      in   NRP*TW    cycles after ID until port p's value is consumed
//  id_grf_rd    in   NRP*DW    raw GRF read data in ID
//  md_busy      in   1         mult/div unit busy
//  id_is_md     in   1         ID instruction uses the mult/div unit
//  stg_wd       in   NSTG*DW   forwardable result of each stage (k at [k*DW+:DW])
//  flush        in   NSTG      per-stage kill (exception/eret), applied at clock edge
//  stall        out  1         freeze PC/IF-ID, insert bubble into EX
//  id_rd        out  NRP*DW    forwarded operands in ID
//  ex_rd        out  NRP*DW    re-forwarded operands in EX (ALU A/B, DM write data path)
// BEHAVIOUR
//  - Entry per stage k: valid, wa, tnew, registered. Reset clears every valid; stall=0; id_rd=id_grf_rd; ex_rd=0.
//  - Each edge: entry[k] <= entry[k-1] with tnew saturating-decremented (0 stays 0).
//    entry[0] <= {~stall & (id_wa!=0), id_wa, id_tnew}; when stall, entry[0] is a bubble (valid=0).
//    Then any entry with flush[k]=1 is cleared; flush wins over the shift.
//  - Match(p,k) = valid[k] & wa[k]==ra_p & ra_p!=0. Youngest match (lowest k) shadows older ones.
//  - Stall = OR over p of (youngest match tnew > tuse_p), OR (id_is_md & md_busy). Combinational, no latency.
//  - id_rd[p]: youngest match with tnew==0 -> stg_wd[k]; otherwise id_grf_rd[p]. A match with 0<tnew<=tuse
//    passes unforwarded data that is corrected later in EX.
//  - EX copy regs {ex_ra, ex_tuse, ex_val} load id_ra, id_tuse-1 (saturating) and id_rd when not stalled.
//    When stalled they load ra=0 (bubble). Reset clears them to 0.
//  - ex_rd[p]: youngest match among stages 1..NSTG-1 with tnew==0 -> stg_wd[k]; otherwise ex_val[p]. Combinational.
//  - A match with tnew>0 while the consumer is in EX is a protocol violation (stall guarantees it can't happen).
//    The bench asserts on it.
//  - Same-address write in several stages: only the youngest is used, never OR-combined.
//  - Reset mid-stall: next cycle stall=0, all entries invalid.
// STRUCTURE
//  - Shared package/header: TW/AW defaults, Tnew/Tuse encodings per instruction class (ALU=1, LOAD=2, MD-read=1, none=0).
//  - One sub-module fwd_pick: given ra and NSTG entries plus a start index, returns hit, tnew and data of the youngest match.
//    Instantiated NRP times for ID and NRP times for EX.
// TESTING
//  - addu $1 (tnew=1) then addu using $1 in EX (tuse=1) -> stall=0; ex_rd[0]=stg_wd[1] (MEM value 0x1234).
//  - lw $2 (tnew=2) then beq $2 (tuse=0) -> stall=1 for 2 cycles.
//    The EX bubble entries are valid=0; the third cycle has id_rd[0]=WB data.
//  - Two writes to $3 in EX and MEM, both with tnew=0 -> id_rd picks the EX value 0xA; the MEM value 0xB is ignored.
//  - Read of $0 with a stage writing $0 -> no stall; id_rd=id_grf_rd.
//  - md_busy=1, id_is_md=1 -> stall=1; md_busy drops -> stall=0 on the same cycle.
//  - flush=3'b011 while lw $4 sits in EX -> next cycle no entry matches $4 and stall=0. Reset asserted mid-stall clears stall next cycle.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared widths and per-class Tnew/Tuse encodings
// for the forwarding scoreboard.
package fwd_scoreboard_pkg;

  localparam int AW_DEF = 5;
  localparam int TW_DEF = 2;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_LOAD,
    CLS_MDRD
  } instCls_e;

  localparam logic [TW_DEF-1:0] TNEW_NONE = 2'd0;
  localparam logic [TW_DEF-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW_DEF-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TW_DEF-1:0] TNEW_MDRD = 2'd1;

  function automatic logic [TW_DEF-1:0] tnewOf(
    input instCls_e cls
  );
    logic [TW_DEF-1:0] t;
    t = TNEW_NONE;
    unique case (cls)
      CLS_ALU:  t = TNEW_ALU;
      CLS_LOAD: t = TNEW_LOAD;
      CLS_MDRD: t = TNEW_MDRD;
      default:  t = TNEW_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_pick.sv
// Youngest-match selector over the tracked
// producer stages, starting at a given stage.
module fwd_pick
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = AW_DEF,
  parameter int TW   = TW_DEF,
  parameter int NSTG = 3
) (
  input  logic [AW-1:0]      ra,
  input  logic [7:0]         start,
  input  logic [NSTG-1:0]    valid,
  input  logic [NSTG*AW-1:0] wa,
  input  logic [NSTG*TW-1:0] tnew,
  input  logic [NSTG*DW-1:0] wd,
  output logic               hit,
  output logic [TW-1:0]      hitTnew,
  output logic [DW-1:0]      hitData
);

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    hit     = 1'b0;
    hitTnew = '0;
    hitData = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (8'(k) >= start && valid[k] &&
          wa[k*AW+:AW] == ra && ra != '0) begin
        hit     = 1'b1;
        hitTnew = tnew[k*TW+:TW];
        hitData = wd[k*DW+:DW];
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight
// GRF writes, raises stall, forwards ID and EX.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = AW_DEF,
  parameter int NRP  = 2,
  parameter int NSTG = 3,
  parameter int TW   = TW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     id_wa,
  input  logic [TW-1:0]     id_tnew,
  input  logic [NRP*AW-1:0] id_ra,
  input  logic [NRP*TW-1:0] id_tuse,
  input  logic [NRP*DW-1:0] id_grf_rd,
  input  logic              md_busy,
  input  logic              id_is_md,
  input  logic [NSTG*DW-1:0] stg_wd,
  input  logic [NSTG-1:0]   flush,
  output logic              stall,
  output logic [NRP*DW-1:0] id_rd,
  output logic [NRP*DW-1:0] ex_rd
);

  logic [NSTG-1:0]    vld;
  logic [NSTG*AW-1:0] wa;
  logic [NSTG*TW-1:0] tn;

  logic [NRP*AW-1:0] exRa;
  logic [NRP*TW-1:0] exTuse;
  logic [NRP*DW-1:0] exVal;

  logic [NRP-1:0]    idHit;
  logic [NRP*TW-1:0] idTnew;
  logic [NRP*DW-1:0] idData;
  logic [NRP-1:0]    exHit;
  logic [NRP*TW-1:0] exTnew;
  logic [NRP*DW-1:0] exData;

  function automatic logic [TW-1:0] satDec(
    input logic [TW-1:0] t
  );
    return (t == '0) ? t : t - 1'b1;
  endfunction

  for (genvar p = 0; p < NRP; p++) begin : gPort
    fwd_pick #(
      .DW(DW), .AW(AW), .TW(TW), .NSTG(NSTG)
    ) uIdPick (
      .ra     (id_ra[p*AW+:AW]),
      .start  (8'd0),
      .valid  (vld),
      .wa     (wa),
      .tnew   (tn),
      .wd     (stg_wd),
      .hit    (idHit[p]),
      .hitTnew(idTnew[p*TW+:TW]),
      .hitData(idData[p*DW+:DW])
    );

    fwd_pick #(
      .DW(DW), .AW(AW), .TW(TW), .NSTG(NSTG)
    ) uExPick (
      .ra     (exRa[p*AW+:AW]),
      .start  (8'd1),
      .valid  (vld),
      .wa     (wa),
      .tnew   (tn),
      .wd     (stg_wd),
      .hit    (exHit[p]),
      .hitTnew(exTnew[p*TW+:TW]),
      .hitData(exData[p*DW+:DW])
    );
  end

  // stall when a producer is later than its consumer needs
  always_comb begin
    stall = id_is_md & md_busy;
    for (int p = 0; p < NRP; p++) begin
      if (idHit[p] &&
          idTnew[p*TW+:TW] > id_tuse[p*TW+:TW])
        stall = 1'b1;
    end
  end

  // operand muxes: ready youngest producer, else fallback
  always_comb begin
    id_rd = id_grf_rd;
    ex_rd = exVal;
    for (int p = 0; p < NRP; p++) begin
      if (idHit[p] && idTnew[p*TW+:TW] == '0)
        id_rd[p*DW+:DW] = idData[p*DW+:DW];
      if (exHit[p] && exTnew[p*TW+:TW] == '0)
        ex_rd[p*DW+:DW] = exData[p*DW+:DW];
    end
  end

  // producer shift chain; flush overrides the shift
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      wa  <= '0;
      tn  <= '0;
    end else begin
      vld[0]     <= ~stall & (id_wa != '0) & ~flush[0];
      wa[0+:AW]  <= id_wa;
      tn[0+:TW]  <= id_tnew;
      for (int k = 1; k < NSTG; k++) begin
        vld[k]       <= vld[k-1] & ~flush[k];
        wa[k*AW+:AW] <= wa[(k-1)*AW+:AW];
        tn[k*TW+:TW] <= satDec(tn[(k-1)*TW+:TW]);
      end
    end
  end

  // EX copies of the ID operands; stall injects a bubble
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      exRa   <= '0;
      exTuse <= '0;
      exVal  <= '0;
    end else begin
      exRa  <= id_ra;
      exVal <= id_rd;
      for (int p = 0; p < NRP; p++)
        exTuse[p*TW+:TW] <= satDec(id_tuse[p*TW+:TW]);
    end
  end

  // an EX consumer must never see a producer still busy
  always_ff @(posedge clk) begin
    for (int p = 0; p < NRP; p++) begin
      if (!reset)
        assert (!(exHit[p] &&
          exTnew[p*TW+:TW] > exTuse[p*TW+:TW]));
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed
// scenarios plus random traffic against a queue model.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRP = 2;
  localparam int NSTG = 3;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] id_wa;
  logic [TW-1:0] id_tnew;
  logic [NRP*AW-1:0] id_ra;
  logic [NRP*TW-1:0] id_tuse;
  logic [NRP*DW-1:0] id_grf_rd;
  logic md_busy;
  logic id_is_md;
  logic [NSTG*DW-1:0] stg_wd;
  logic [NSTG-1:0] flush;
  logic stall;
  logic [NRP*DW-1:0] id_rd;
  logic [NRP*DW-1:0] ex_rd;

  int nChecks = 0;
  int nFails = 0;

  fwd_scoreboard #(
    .DW(DW), .AW(AW), .NRP(NRP), .NSTG(NSTG), .TW(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_wa(id_wa), .id_tnew(id_tnew),
    .id_ra(id_ra), .id_tuse(id_tuse),
    .id_grf_rd(id_grf_rd),
    .md_busy(md_busy), .id_is_md(id_is_md),
    .stg_wd(stg_wd), .flush(flush),
    .stall(stall), .id_rd(id_rd), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  // reference model: in-flight producers, youngest first
  typedef struct {
    int wa;
    int tnew;
    int birth;
  } prod_t;

  prod_t q[$];
  int cyc;
  int exRaM[NRP];
  int exTuseM[NRP];
  logic [DW-1:0] exValM[NRP];

  function automatic int ageOf(prod_t e);
    return cyc - e.birth;
  endfunction

  function automatic int remOf(prod_t e);
    int a;
    a = cyc - e.birth;
    return (e.tnew > a) ? e.tnew - a : 0;
  endfunction

  function automatic int findYoungest(int ra, int minAge);
    for (int i = 0; i < q.size(); i++)
      if (ra != 0 && q[i].wa == ra && ageOf(q[i]) >= minAge)
        return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    id_wa = '0; id_tnew = '0; id_ra = '0; id_tuse = '0;
    id_grf_rd = {$urandom, $urandom};
    md_busy = 1'b0; id_is_md = 1'b0;
    stg_wd = {$urandom, $urandom, $urandom};
    flush = '0;
  endtask

  task automatic setInst(input int wa, input int tnew,
                         input int ra0, input int tuse0,
                         input int ra1, input int tuse1);
    id_wa = AW'(wa);
    id_tnew = TW'(tnew);
    id_ra = {AW'(ra1), AW'(ra0)};
    id_tuse = {TW'(tuse1), TW'(tuse0)};
  endtask

  task automatic doReset();
    reset = 1'b1;
    setIdle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #2;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    nChecks++;
    if (id_rd !== id_grf_rd) begin
      nFails++; $display("FAIL reset_id_rd: got %h want %h", id_rd, id_grf_rd);
    end
    nChecks++;
    if (ex_rd !== '0) begin
      nFails++; $display("FAIL reset_ex_rd: got %h want 0", ex_rd);
    end
  endtask

  task automatic test_alu_fwd();
    logic [DW-1:0] grf1;
    doReset();
    setInst(1, int'(TNEW_ALU), 0, 0, 0, 0);
    tick();
    setInst(5, int'(TNEW_ALU), 1, 1, 0, 0);
    id_grf_rd = {32'h5555_0001, 32'h0000_DEAD};
    grf1 = 32'h5555_0001;
    #2;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL alu_stall: got %b want 0", stall);
    end
    nChecks++;
    if (id_rd[DW-1:0] !== 32'h0000_DEAD) begin
      nFails++; $display("FAIL alu_id_unfwd: got %h want 0000dead", id_rd[DW-1:0]);
    end
    tick();
    setIdle();
    stg_wd[DW+:DW] = 32'h0000_1234;
    #2;
    nChecks++;
    if (ex_rd[DW-1:0] !== 32'h0000_1234) begin
      nFails++; $display("FAIL alu_ex_fwd: got %h want 00001234", ex_rd[DW-1:0]);
    end
    nChecks++;
    if (ex_rd[2*DW-1:DW] !== grf1) begin
      nFails++; $display("FAIL alu_ex_port1: got %h want %h", ex_rd[2*DW-1:DW], grf1);
    end
  endtask

  task automatic test_load_use();
    doReset();
    setInst(2, int'(TNEW_LOAD), 0, 0, 0, 0);
    tick();
    setInst(0, 0, 2, 0, 0, 0);
    #2;
    nChecks++;
    if (stall !== 1'b1) begin
      nFails++; $display("FAIL lu_stall1: got %b want 1", stall);
    end
    tick();
    #2;
    nChecks++;
    if (stall !== 1'b1) begin
      nFails++; $display("FAIL lu_stall2: got %b want 1", stall);
    end
    nChecks++;
    if (dut.vld[0] !== 1'b0) begin
      nFails++; $display("FAIL lu_bubble: got %b want 0", dut.vld[0]);
    end
    tick();
    stg_wd[2*DW+:DW] = 32'hCAFE_0002;
    #2;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL lu_stall3: got %b want 0", stall);
    end
    nChecks++;
    if (id_rd[DW-1:0] !== 32'hCAFE_0002) begin
      nFails++; $display("FAIL lu_wb_fwd: got %h want cafe0002", id_rd[DW-1:0]);
    end
  endtask

  task automatic test_youngest();
    doReset();
    setInst(3, 0, 0, 0, 0, 0);
    tick();
    setInst(3, 0, 0, 0, 0, 0);
    tick();
    setInst(0, 0, 3, 0, 0, 0);
    stg_wd[0+:DW] = 32'h0000_000A;
    stg_wd[DW+:DW] = 32'h0000_000B;
    #2;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL yng_stall: got %b want 0", stall);
    end
    nChecks++;
    if (id_rd[DW-1:0] !== 32'h0000_000A) begin
      nFails++; $display("FAIL yng_id: got %h want 0000000a", id_rd[DW-1:0]);
    end
    tick();
    setIdle();
    stg_wd[DW+:DW] = 32'h0000_00A1;
    stg_wd[2*DW+:DW] = 32'h0000_00B1;
    #2;
    nChecks++;
    if (ex_rd[DW-1:0] !== 32'h0000_00A1) begin
      nFails++; $display("FAIL yng_ex: got %h want 000000a1", ex_rd[DW-1:0]);
    end
  endtask

  task automatic test_zero_reg();
    doReset();
    setInst(0, int'(TNEW_LOAD), 0, 0, 0, 0);
    tick();
    setInst(0, 0, 0, 0, 0, 0);
    #2;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL zero_stall: got %b want 0", stall);
    end
    nChecks++;
    if (id_rd !== id_grf_rd) begin
      nFails++; $display("FAIL zero_id_rd: got %h want %h", id_rd, id_grf_rd);
    end
  endtask

  task automatic test_md();
    doReset();
    id_is_md = 1'b1; md_busy = 1'b1;
    #2;
    nChecks++;
    if (stall !== 1'b1) begin
      nFails++; $display("FAIL md_busy: got %b want 1", stall);
    end
    md_busy = 1'b0;
    #1;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL md_release: got %b want 0", stall);
    end
    id_is_md = 1'b0; md_busy = 1'b1;
    #1;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL md_not_md: got %b want 0", stall);
    end
    md_busy = 1'b0;
  endtask

  task automatic test_flush();
    doReset();
    setInst(4, int'(TNEW_LOAD), 0, 0, 0, 0);
    tick();
    setIdle();
    flush = 3'b011;
    tick();
    flush = '0;
    setInst(0, 0, 4, 0, 0, 0);
    #2;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL flush_stall: got %b want 0", stall);
    end
    nChecks++;
    if (id_rd[DW-1:0] !== id_grf_rd[DW-1:0]) begin
      nFails++; $display("FAIL flush_id_rd: got %h want %h", id_rd[DW-1:0], id_grf_rd[DW-1:0]);
    end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    setInst(6, int'(TNEW_LOAD), 0, 0, 0, 0);
    tick();
    setInst(0, 0, 6, 0, 0, 0);
    #2;
    nChecks++;
    if (stall !== 1'b1) begin
      nFails++; $display("FAIL rms_pre: got %b want 1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("FAIL rms_post: got %b want 0", stall);
    end
    nChecks++;
    if (dut.vld !== '0) begin
      nFails++; $display("FAIL rms_entries: got %b want 000", dut.vld);
    end
  endtask

  task automatic test_random();
    logic stallE;
    logic [DW-1:0] idE[NRP];
    logic [DW-1:0] exE[NRP];
    int ra, tu, i;
    doReset();
    q.delete();
    cyc = 0;
    for (int p = 0; p < NRP; p++) begin
      exRaM[p] = 0; exTuseM[p] = 0; exValM[p] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      setInst($urandom_range(0, 4), $urandom_range(0, 2),
              $urandom_range(0, 4), $urandom_range(0, 2),
              $urandom_range(0, 4), $urandom_range(0, 2));
      id_grf_rd = {$urandom, $urandom};
      stg_wd = {$urandom, $urandom, $urandom};
      md_busy = ($urandom_range(0, 7) == 0);
      id_is_md = 1'($urandom_range(0, 1));
      flush = '0;
      stallE = id_is_md & md_busy;
      for (int p = 0; p < NRP; p++) begin
        ra = int'(id_ra[p*AW+:AW]);
        tu = int'(id_tuse[p*TW+:TW]);
        i = findYoungest(ra, 0);
        idE[p] = id_grf_rd[p*DW+:DW];
        if (i >= 0) begin
          if (remOf(q[i]) > tu) stallE = 1'b1;
          if (remOf(q[i]) == 0)
            idE[p] = stg_wd[ageOf(q[i])*DW+:DW];
        end
        i = findYoungest(exRaM[p], 1);
        exE[p] = exValM[p];
        if (i >= 0) begin
          nChecks++;
          if (remOf(q[i]) > exTuseM[p]) begin
            nFails++; $display("FAIL rnd_protocol: port %0d tnew %0d tuse %0d", p, remOf(q[i]), exTuseM[p]);
          end
          if (remOf(q[i]) == 0)
            exE[p] = stg_wd[ageOf(q[i])*DW+:DW];
        end
      end
      #2;
      nChecks++;
      if (stall !== stallE) begin
        nFails++; $display("FAIL rnd_stall: cyc %0d got %b want %b", n, stall, stallE);
      end
      for (int p = 0; p < NRP; p++) begin
        nChecks++;
        if (id_rd[p*DW+:DW] !== idE[p]) begin
          nFails++; $display("FAIL rnd_id_rd: cyc %0d port %0d got %h want %h", n, p, id_rd[p*DW+:DW], idE[p]);
        end
        nChecks++;
        if (ex_rd[p*DW+:DW] !== exE[p]) begin
          nFails++; $display("FAIL rnd_ex_rd: cyc %0d port %0d got %h want %h", n, p, ex_rd[p*DW+:DW], exE[p]);
        end
      end
      @(posedge clk);
      cyc++;
      if (!stallE && id_wa != '0)
        q.push_front('{int'(id_wa), int'(id_tnew), cyc});
      while (q.size() > 0 && ageOf(q[q.size()-1]) >= NSTG)
        void'(q.pop_back());
      for (int p = 0; p < NRP; p++) begin
        if (stallE) begin
          exRaM[p] = 0; exTuseM[p] = 0; exValM[p] = '0;
        end else begin
          exRaM[p] = int'(id_ra[p*AW+:AW]);
          tu = int'(id_tuse[p*TW+:TW]);
          exTuseM[p] = (tu > 0) ? tu - 1 : 0;
          exValM[p] = idE[p];
        end
      end
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    setIdle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_md();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
